// File: rtl/caliptra_ss_soc_rst_seq_if.sv
// Request/acknowledge and status bundle of the SoC reset sequencer.
// master = SoC-side requester, slave = sequencer.
interface caliptra_ss_soc_rst_seq_if;
   logic       hard_on_req_i;
   logic       hard_off_req_i;
   logic       warm_rst_req_i;
   logic       warm_rel_req_i;
   logic       mcu_halt_ack_i;
   logic       cptra_pwrgood_o;
   logic       cptra_rst_b_o;
   logic       mcu_halt_req_o;
   logic       done_o;
   logic       req_ignored_o;
   logic       halt_timeout_o;
   logic [2:0] state_o;

   modport master (
      output hard_on_req_i, hard_off_req_i, warm_rst_req_i, warm_rel_req_i, mcu_halt_ack_i,
      input  cptra_pwrgood_o, cptra_rst_b_o, mcu_halt_req_o, done_o, req_ignored_o,
             halt_timeout_o, state_o
   );

   modport slave (
      input  hard_on_req_i, hard_off_req_i, warm_rst_req_i, warm_rel_req_i, mcu_halt_ack_i,
      output cptra_pwrgood_o, cptra_rst_b_o, mcu_halt_req_o, done_o, req_ignored_o,
             halt_timeout_o, state_o
   );
endinterface

// File: rtl/caliptra_ss_soc_rst_seq.sv
// Subsystem power-good / reset sequencer with MCU halt handshake.
// One shared 16-bit down-counter times every delay state; all outputs are registered.
module caliptra_ss_soc_rst_seq #(
   parameter int unsigned PWRGOOD_DLY  = 5,
   parameter int unsigned RST_DLY      = 100,
   parameter int unsigned HALT_TIMEOUT = 100
) (
   input logic                        core_clk,
   input logic                        rst_b,
   caliptra_ss_soc_rst_seq_if.slave   sif
);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_PWR_DLY = 3'd1,
      ST_PWR_ON  = 3'd2,
      ST_RST_DLY = 3'd3,
      ST_RUN     = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   generate
      if (PWRGOOD_DLY > 65535 || RST_DLY > 65535 || HALT_TIMEOUT > 65535) begin : g_bad_param
         $error("caliptra_ss_soc_rst_seq: delay parameters must fit the 16-bit counter");
      end
   endgenerate

   localparam logic [15:0] PWRGOOD_CNT = 16'(PWRGOOD_DLY);
   localparam logic [15:0] RST_CNT     = 16'(RST_DLY);
   localparam logic [15:0] HALT_CNT    = 16'(HALT_TIMEOUT);

   state_t      state_reg;
   logic [15:0] cnt_reg;
   logic        pwrgood_reg;
   logic        rst_b_o_reg;
   logic        halt_req_reg;
   logic        hard_type_reg;
   logic        done_reg;
   logic        ignored_reg;
   logic        timeout_reg;

   logic acc_off, acc_warm, acc_on, acc_rel, ignored_next;

   // Pick the single request this state acts on (hard_off > warm_rst > hard_on > warm_rel);
   // every other asserted request is reported as ignored, never queued.
   always_comb begin
      acc_off  = sif.hard_off_req_i &&
                 (state_reg == ST_PWR_DLY || state_reg == ST_RST_DLY ||
                  state_reg == ST_PWR_ON  || state_reg == ST_RUN);
      acc_warm = sif.warm_rst_req_i && (state_reg == ST_RUN) && !acc_off;
      acc_on   = sif.hard_on_req_i  && (state_reg == ST_OFF) && !acc_off && !acc_warm;
      acc_rel  = sif.warm_rel_req_i && (state_reg == ST_PWR_ON) && !acc_off;
      ignored_next = (sif.hard_off_req_i && !acc_off)  || (sif.warm_rst_req_i && !acc_warm) ||
                     (sif.hard_on_req_i  && !acc_on)   || (sif.warm_rel_req_i && !acc_rel);
   end

   always_ff @(posedge core_clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg     <= ST_OFF;
         cnt_reg       <= '0;
         pwrgood_reg   <= 1'b0;
         rst_b_o_reg   <= 1'b0;
         halt_req_reg  <= 1'b0;
         hard_type_reg <= 1'b0;
         done_reg      <= 1'b0;
         ignored_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         ignored_reg <= ignored_next;
         case (state_reg)
            ST_OFF: begin
               if (acc_on) begin
                  cnt_reg   <= PWRGOOD_CNT;
                  state_reg <= ST_PWR_DLY;
               end
            end
            ST_PWR_DLY, ST_RST_DLY: begin
               if (acc_off) begin
                  pwrgood_reg <= 1'b0;
                  rst_b_o_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  cnt_reg     <= '0;
                  state_reg   <= ST_OFF;
               end else if (cnt_reg != 16'd0) begin
                  cnt_reg <= cnt_reg - 16'd1;
               end else if (state_reg == ST_PWR_DLY) begin
                  pwrgood_reg <= 1'b1;
                  cnt_reg     <= RST_CNT;
                  state_reg   <= ST_RST_DLY;
               end else begin
                  rst_b_o_reg <= 1'b1;
                  done_reg    <= 1'b1;
                  state_reg   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (acc_off || acc_warm) begin
                  halt_req_reg  <= 1'b1;
                  cnt_reg       <= HALT_CNT;
                  hard_type_reg <= acc_off;
                  state_reg     <= ST_HALT;
               end
            end
            ST_HALT: begin
               // An ack on the same edge the counter expires wins: no timeout flag.
               if (sif.mcu_halt_ack_i || cnt_reg == 16'd0) begin
                  halt_req_reg <= 1'b0;
                  rst_b_o_reg  <= 1'b0;
                  done_reg     <= 1'b1;
                  if (!sif.mcu_halt_ack_i) timeout_reg <= 1'b1;
                  if (hard_type_reg) begin
                     pwrgood_reg <= 1'b0;
                     state_reg   <= ST_OFF;
                  end else begin
                     state_reg   <= ST_PWR_ON;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 16'd1;
               end
            end
            ST_PWR_ON: begin
               if (acc_off) begin
                  pwrgood_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  state_reg   <= ST_OFF;
               end else if (acc_rel) begin
                  cnt_reg   <= RST_CNT;
                  state_reg <= ST_RST_DLY;
               end
            end
            default: begin
               pwrgood_reg  <= 1'b0;
               rst_b_o_reg  <= 1'b0;
               halt_req_reg <= 1'b0;
               state_reg    <= ST_OFF;
            end
         endcase
      end
   end

   assign sif.cptra_pwrgood_o = pwrgood_reg;
   assign sif.cptra_rst_b_o   = rst_b_o_reg;
   assign sif.mcu_halt_req_o  = halt_req_reg;
   assign sif.done_o          = done_reg;
   assign sif.req_ignored_o   = ignored_reg;
   assign sif.halt_timeout_o  = timeout_reg;
   assign sif.state_o         = state_reg;

endmodule

// File: tb/tb_caliptra_ss_soc_rst_seq.sv
// Scoreboard bench: scenario tasks push timed expected output events computed from the
// sequencing rules; a negedge monitor pops one event whenever an observable output changes/pulses.
module tb_caliptra_ss_soc_rst_seq;
   localparam int PD = 5;
   localparam int RD = 100;
   localparam int HT = 100;
   localparam logic [2:0] S_OFF = 3'd0, S_PDLY = 3'd1, S_PON = 3'd2,
                          S_RDLY = 3'd3, S_RUN = 3'd4, S_HALT = 3'd5;
   localparam int M_OFF = 0, M_PON = 1, M_RUN = 2;

   logic core_clk = 1'b0;
   logic rst_b    = 1'b0;
   caliptra_ss_soc_rst_seq_if sif();

   caliptra_ss_soc_rst_seq #(.PWRGOOD_DLY(PD), .RST_DLY(RD), .HALT_TIMEOUT(HT)) dut (
      .core_clk (core_clk),
      .rst_b    (rst_b),
      .sif      (sif)
   );

   always #5 core_clk = ~core_clk;

   int cyc = 0;
   always @(posedge core_clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [8:0] v;   // {pg, rb, hr, done, ign, timeout, state}
   } ev_t;

   ev_t  exp_q[$];
   int   tests = 0;
   int   failed = 0;
   bit   mon_en = 1'b0;
   int   mode = M_OFF;
   logic to_m = 1'b0;
   logic ppg, prb, phr, pto;

   function automatic logic [8:0] pack(input logic pg, rb, hr, dn, ig, to, input logic [2:0] st);
      return {pg, rb, hr, dn, ig, to, st};
   endfunction

   task automatic expect_ev(input int c, input logic pg, rb, hr, dn, ig, to, input logic [2:0] st);
      ev_t e;
      e.cyc = c;
      e.v   = pack(pg, rb, hr, dn, ig, to, st);
      exp_q.push_back(e);
   endtask

   // Monitor: any pulse or level change on the outputs is one DUT transaction.
   always @(negedge core_clk) begin : monitor
      ev_t        e;
      logic [8:0] got;
      if (mon_en) begin
         got = pack(sif.cptra_pwrgood_o, sif.cptra_rst_b_o, sif.mcu_halt_req_o, sif.done_o,
                    sif.req_ignored_o, sif.halt_timeout_o, sif.state_o);
         tests++;
         if (sif.cptra_rst_b_o && !sif.cptra_pwrgood_o) begin
            failed++;
            $display("FAIL rst_b_while_no_pwrgood cyc=%0d rb=%b pg=%b required rb=0", cyc,
                     sif.cptra_rst_b_o, sif.cptra_pwrgood_o);
         end
         if (sif.done_o || sif.req_ignored_o || got[8] != ppg || got[7] != prb ||
             got[6] != phr || got[3] != pto) begin
            tests++;
            if (exp_q.size() == 0) begin
               failed++;
               $display("FAIL unexpected_event cyc=%0d got pg,rb,hr,dn,ig,to=%b st=%0d required no event",
                        cyc, got[8:3], got[2:0]);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v != got) begin
                  failed++;
                  $display("FAIL event cyc=%0d got pg,rb,hr,dn,ig,to=%b st=%0d required cyc=%0d pg,rb,hr,dn,ig,to=%b st=%0d",
                           cyc, got[8:3], got[2:0], e.cyc, e.v[8:3], e.v[2:0]);
               end else begin
                  $display("[TB] event cyc=%0d pg,rb,hr,dn,ig,to=%b st=%0d ok", cyc, got[8:3], got[2:0]);
               end
            end
         end
         ppg = got[8];
         prb = got[7];
         phr = got[6];
         pto = got[3];
      end
   end

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge core_clk);
   endtask

   task automatic drain(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL %s pending=%0d next expected cyc=%0d now=%0d required all events seen",
                  name, exp_q.size(), exp_q[0].cyc, cyc);
         exp_q.delete();
      end
   endtask

   task automatic start_req(input logic [3:0] m, output int s);
      @(negedge core_clk);
      sif.hard_off_req_i = m[3];
      sif.warm_rst_req_i = m[2];
      sif.hard_on_req_i  = m[1];
      sif.warm_rel_req_i = m[0];
      s = cyc + 1;
   endtask

   task automatic end_req();
      @(negedge core_clk);
      sif.hard_off_req_i = 1'b0;
      sif.warm_rst_req_i = 1'b0;
      sif.hard_on_req_i  = 1'b0;
      sif.warm_rel_req_i = 1'b0;
   endtask

   task automatic do_ignored(input logic [3:0] m);
      int s;
      logic pg, rb;
      logic [2:0] st;
      pg = (mode != M_OFF);
      rb = (mode == M_RUN);
      st = (mode == M_OFF) ? S_OFF : (mode == M_PON) ? S_PON : S_RUN;
      start_req(m, s);
      $display("[TB] txn ignored mask=%b edge=%0d", m, s);
      expect_ev(s, pg, rb, 1'b0, 1'b0, 1'b1, to_m, st);
      end_req();
      wait_until(s + 2);
      drain("ignored");
   endtask

   // abort_k < 0: full power-up; else hard_off sampled abort_k edges after the request.
   task automatic do_power_up(input logic [3:0] inj, input int abort_k);
      int s, t, pg_edge, done_edge, last;
      start_req(4'b0010, s);
      $display("[TB] txn power_up edge=%0d inj=%b abort=%0d", s, inj, abort_k);
      pg_edge   = s + PD + 1;
      done_edge = s + PD + RD + 2;
      t = 0;
      if (abort_k < 0) begin
         expect_ev(pg_edge, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, to_m, S_RDLY);
         if (inj != 4'b0000) begin
            t = pg_edge + int'($urandom_range(1, RD));
            expect_ev(t, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, to_m, S_RDLY);
         end
         expect_ev(done_edge, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, to_m, S_RUN);
         last = done_edge;
      end else begin
         t = s + abort_k;
         if (t > pg_edge) expect_ev(pg_edge, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, to_m, S_RDLY);
         expect_ev(t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, to_m, S_OFF);
         last = t;
      end
      end_req();
      if (abort_k >= 0 || inj != 4'b0000) begin
         wait_until(t - 1);
         sif.hard_off_req_i = (abort_k >= 0);
         sif.warm_rst_req_i = (abort_k < 0) && inj[2];
         sif.hard_on_req_i  = (abort_k < 0) && inj[1];
         sif.warm_rel_req_i = (abort_k < 0) && inj[0];
         end_req();
      end
      wait_until(last + 2);
      drain("power_up");
      mode = (abort_k < 0) ? M_RUN : M_OFF;
   endtask

   // ack sampled d edges after the request; d > HT+1 means the ack never comes.
   task automatic do_halt(input bit hard, input bit both, input int d);
      int s, e;
      logic [3:0] m;
      m = hard ? (both ? 4'b1100 : 4'b1000) : 4'b0100;
      start_req(m, s);
      $display("[TB] txn halt edge=%0d hard=%0d both=%0d ack_dly=%0d", s, hard, both, d);
      expect_ev(s, 1'b1, 1'b1, 1'b1, 1'b0, both, to_m, S_HALT);
      if (d <= HT + 1) begin
         e = s + d;
      end else begin
         e = s + HT + 1;
         to_m = 1'b1;
      end
      expect_ev(e, !hard, 1'b0, 1'b0, 1'b1, 1'b0, to_m, hard ? S_OFF : S_PON);
      end_req();
      if (d <= HT + 1) begin
         wait_until(e - 1);
         sif.mcu_halt_ack_i = 1'b1;
         @(negedge core_clk);
         sif.mcu_halt_ack_i = 1'b0;
      end
      wait_until(e + 2);
      drain("halt");
      mode = hard ? M_OFF : M_PON;
   endtask

   task automatic do_warm_rel();
      int s;
      start_req(4'b0001, s);
      $display("[TB] txn warm_rel edge=%0d", s);
      expect_ev(s + RD + 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, to_m, S_RUN);
      end_req();
      wait_until(s + RD + 3);
      drain("warm_rel");
      mode = M_RUN;
   endtask

   task automatic do_pon_off();
      int s;
      start_req(4'b1000, s);
      $display("[TB] txn pwr_on_hard_off edge=%0d", s);
      expect_ev(s, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, to_m, S_OFF);
      end_req();
      wait_until(s + 2);
      drain("pwr_on_off");
      mode = M_OFF;
   endtask

   task automatic do_async_rst();
      int s;
      start_req(4'b0100, s);
      $display("[TB] txn async_reset_in_halt edge=%0d", s);
      expect_ev(s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, to_m, S_HALT);
      end_req();
      wait_until(s + 5);
      #1 rst_b = 1'b0;
      to_m = 1'b0;
      expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OFF);
      #1;
      tests++;
      if (pack(sif.cptra_pwrgood_o, sif.cptra_rst_b_o, sif.mcu_halt_req_o, sif.done_o,
               sif.req_ignored_o, sif.halt_timeout_o, sif.state_o) != 9'd0) begin
         failed++;
         $display("FAIL async_reset_outputs pg=%b rb=%b hr=%b dn=%b ig=%b to=%b st=%0d required all 0",
                  sif.cptra_pwrgood_o, sif.cptra_rst_b_o, sif.mcu_halt_req_o, sif.done_o,
                  sif.req_ignored_o, sif.halt_timeout_o, sif.state_o);
      end
      repeat (3) @(negedge core_clk);
      #1 rst_b = 1'b1;
      repeat (3) @(negedge core_clk);
      drain("async_reset");
      mode = M_OFF;
   endtask

   initial begin
      sif.hard_on_req_i  = 1'b0;
      sif.hard_off_req_i = 1'b0;
      sif.warm_rst_req_i = 1'b0;
      sif.warm_rel_req_i = 1'b0;
      sif.mcu_halt_ack_i = 1'b0;
      repeat (3) @(negedge core_clk);
      tests++;
      if (pack(sif.cptra_pwrgood_o, sif.cptra_rst_b_o, sif.mcu_halt_req_o, sif.done_o,
               sif.req_ignored_o, sif.halt_timeout_o, sif.state_o) != 9'd0) begin
         failed++;
         $display("FAIL reset_state pg=%b rb=%b hr=%b dn=%b ig=%b to=%b st=%0d required all 0",
                  sif.cptra_pwrgood_o, sif.cptra_rst_b_o, sif.mcu_halt_req_o, sif.done_o,
                  sif.req_ignored_o, sif.halt_timeout_o, sif.state_o);
      end
      rst_b = 1'b1;
      ppg = 1'b0; prb = 1'b0; phr = 1'b0; pto = 1'b0;
      mon_en = 1'b1;
      repeat (5) @(negedge core_clk);
      drain("idle_after_reset");

      do_ignored(4'b0001);
      do_power_up(4'b0000, -1);
      do_ignored(4'b0001);
      do_halt(1'b0, 1'b0, 10);
      do_ignored(4'b0010);
      do_warm_rel();
      do_halt(1'b0, 1'b0, HT + 1);
      do_pon_off();
      do_power_up(4'b0000, PD + 1 + 50);
      do_power_up(4'b0000, PD + 1);
      do_power_up(4'b0110, -1);
      do_halt(1'b1, 1'b1, 200);
      do_power_up(4'b0000, -1);
      do_async_rst();

      for (int i = 0; i < 25; i++) begin
         int r;
         logic [2:0] m;
         r = int'($urandom_range(0, 4));
         m = 3'($urandom_range(1, 7));
         case (mode)
            M_OFF: begin
               if (r == 0) do_ignored({m[2], m[1], 1'b0, m[0]});
               else if (r == 1) do_power_up(4'b0000, int'($urandom_range(1, PD + RD + 1)));
               else do_power_up({1'b0, m}, -1);
            end
            M_PON: begin
               if (r == 0) do_ignored({1'b0, 2'($urandom_range(1, 3)), 1'b0});
               else if (r == 1) do_pon_off();
               else do_warm_rel();
            end
            default: begin
               if (r == 0) do_ignored({2'b00, 2'($urandom_range(1, 3))});
               else if (r == 4) do_async_rst();
               else do_halt(m[0], m[1], int'($urandom_range(1, 130)));
            end
         endcase
      end

      repeat (3) @(negedge core_clk);
      drain("final");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog cyc=%0d required completion before time limit", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
